// File: rtl/branch_predictor_unit.sv
// -----------------------------------------------------------------------------
// branch_predictor_unit
//
// Dynamic conditional-branch predictor that also checks its own predictions
// when the branch resolves.
//
//   Fetch side   : a table of 2-bit saturating counters (PHT) is indexed by the
//                  low IDX_W bits of fetch_pc. The counter MSB is the
//                  taken/not-taken prediction, read combinationally.
//   Resolve side : the real outcome is taken from W_zero, W_negative or carry,
//                  depending on the branch type. This outcome is compared with
//                  the prediction that fetch made for the branch. On a
//                  mismatch a one-cycle flush pulse and a recovery address are
//                  produced. Every conditional resolution trains the PHT and
//                  updates the hit/miss statistics.
//
// Ports
//   clk               in   1       system clock, all state on rising edge
//   reset_n           in   1       synchronous reset, active low
//   fetch_pc          in   ADDR_W  PC of the instruction being fetched
//   fetch_predict     out  1       PHT prediction for fetch_pc
//   res_valid         in   1       a branch is being resolved this cycle
//   res_pc            in   ADDR_W  PC of the resolving branch
//   res_branch_type   in   2       00 none, 01 zero, 10 negative, 11 carry
//   res_pred_taken    in   1       prediction made for this branch at fetch
//   res_target        in   ADDR_W  branch target address
//   res_fallthrough   in   ADDR_W  sequential address after the branch
//   W_zero            in   1       W zero flag
//   W_negative        in   1       W negative flag
//   carry             in   1       carry flag
//   prediction_failed out  1       registered 1-cycle pulse on a misprediction
//   flush             out  1       same pulse as prediction_failed
//   branch_result     out  1       actual outcome of last resolved branch
//   failback_addr     out  ADDR_W  recovery address of last resolved branch
//   branch_count      out  STAT_W  conditional branches resolved (saturating)
//   miss_count        out  STAT_W  mispredictions (saturating)
// -----------------------------------------------------------------------------
module branch_predictor_unit #(
    parameter int ADDR_W = 11,
    parameter int IDX_W  = 4,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              fetch_predict,
    input  logic              res_valid,
    input  logic [ADDR_W-1:0] res_pc,
    input  logic [1:0]        res_branch_type,
    input  logic              res_pred_taken,
    input  logic [ADDR_W-1:0] res_target,
    input  logic [ADDR_W-1:0] res_fallthrough,
    input  logic              W_zero,
    input  logic              W_negative,
    input  logic              carry,
    output logic              prediction_failed,
    output logic              flush,
    output logic              branch_result,
    output logic [ADDR_W-1:0] failback_addr,
    output logic [STAT_W-1:0] branch_count,
    output logic [STAT_W-1:0] miss_count
);

    localparam int PHT_DEPTH = 2 ** IDX_W;

    localparam logic [1:0] CNT_STRONG_NT = 2'b00;
    localparam logic [1:0] CNT_WEAK_NT   = 2'b01;
    localparam logic [1:0] CNT_STRONG_T  = 2'b11;

    localparam logic [1:0] BT_NONE = 2'b00;
    localparam logic [1:0] BT_ZERO = 2'b01;
    localparam logic [1:0] BT_NEG  = 2'b10;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PHT_DEPTH-1:0][1:0] pht_q, pht_d;
    logic                      failed_q, failed_d;
    logic                      result_q, result_d;
    logic [ADDR_W-1:0]         failback_q, failback_d;
    logic [STAT_W-1:0]         branch_cnt_q, branch_cnt_d;
    logic [STAT_W-1:0]         miss_cnt_q, miss_cnt_d;

    // ------------------------------------------------------------------
    // Index extraction. Upper PC bits are unused because no tags are
    // kept, so aliasing PCs share one counter.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] res_idx;

    assign fetch_idx = fetch_pc[IDX_W-1:0];
    assign res_idx   = res_pc[IDX_W-1:0];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[ADDR_W-1:IDX_W], res_pc[ADDR_W-1:IDX_W]};

    // The read uses the registered table, so a training write at the same
    // index becomes visible only from the following cycle.
    assign fetch_predict = pht_q[fetch_idx][1];

    // ------------------------------------------------------------------
    // Resolution evaluation
    // ------------------------------------------------------------------
    logic       res_cond;
    logic       actual_taken;
    logic       mispredict;
    logic [1:0] res_cnt;

    always_comb begin
        res_cond     = res_valid && (res_branch_type != BT_NONE);
        actual_taken = 1'b0;
        case (res_branch_type)
            BT_ZERO: actual_taken = W_zero;
            BT_NEG:  actual_taken = W_negative;
            default: actual_taken = carry;
        endcase
        mispredict = res_cond && (actual_taken != res_pred_taken);
        res_cnt    = pht_q[res_idx];
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        pht_d        = pht_q;
        failed_d     = 1'b0;
        result_d     = result_q;
        failback_d   = failback_q;
        branch_cnt_d = branch_cnt_q;
        miss_cnt_d   = miss_cnt_q;

        if (res_cond) begin
            result_d   = actual_taken;
            failed_d   = mispredict;
            // Recovery goes to whichever path was not predicted.
            failback_d = res_pred_taken ? res_fallthrough : res_target;

            if (actual_taken) begin
                if (res_cnt != CNT_STRONG_T) begin
                    pht_d[res_idx] = res_cnt + 2'd1;
                end
            end else begin
                if (res_cnt != CNT_STRONG_NT) begin
                    pht_d[res_idx] = res_cnt - 2'd1;
                end
            end

            // Statistics stick at all-ones instead of wrapping.
            if (branch_cnt_q != '1) begin
                branch_cnt_d = branch_cnt_q + STAT_W'(1);
            end
            if (mispredict && (miss_cnt_q != '1)) begin
                miss_cnt_d = miss_cnt_q + STAT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers. Reset takes priority over a simultaneous resolve.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pht_q        <= {PHT_DEPTH{CNT_WEAK_NT}};
            failed_q     <= 1'b0;
            result_q     <= 1'b0;
            failback_q   <= '0;
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            pht_q        <= pht_d;
            failed_q     <= failed_d;
            result_q     <= result_d;
            failback_q   <= failback_d;
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign prediction_failed = failed_q;
    assign flush             = failed_q;
    assign branch_result     = result_q;
    assign failback_addr     = failback_q;
    assign branch_count      = branch_cnt_q;
    assign miss_count        = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor_unit.sv
module tb_branch_predictor_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] fetch_pc;
    logic        res_valid;
    logic [10:0] res_pc;
    logic [1:0]  res_branch_type;
    logic        res_pred_taken;
    logic [10:0] res_target;
    logic [10:0] res_fallthrough;
    logic        W_zero, W_negative, carry;

    logic        fetch_predict, prediction_failed, flush, branch_result;
    logic [10:0] failback_addr;
    logic [15:0] branch_count, miss_count;

    logic        fetch_predict4, prediction_failed4, flush4, branch_result4;
    logic [10:0] failback_addr4;
    logic [3:0]  branch_count4, miss_count4;

    always #5 clk = ~clk;

    branch_predictor_unit dut (
        .clk(clk), .reset_n(reset_n), .fetch_pc(fetch_pc), .fetch_predict(fetch_predict),
        .res_valid(res_valid), .res_pc(res_pc), .res_branch_type(res_branch_type),
        .res_pred_taken(res_pred_taken), .res_target(res_target),
        .res_fallthrough(res_fallthrough), .W_zero(W_zero), .W_negative(W_negative),
        .carry(carry), .prediction_failed(prediction_failed), .flush(flush),
        .branch_result(branch_result), .failback_addr(failback_addr),
        .branch_count(branch_count), .miss_count(miss_count)
    );

    branch_predictor_unit #(.STAT_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .fetch_pc(fetch_pc), .fetch_predict(fetch_predict4),
        .res_valid(res_valid), .res_pc(res_pc), .res_branch_type(res_branch_type),
        .res_pred_taken(res_pred_taken), .res_target(res_target),
        .res_fallthrough(res_fallthrough), .W_zero(W_zero), .W_negative(W_negative),
        .carry(carry), .prediction_failed(prediction_failed4), .flush(flush4),
        .branch_result(branch_result4), .failback_addr(failback_addr4),
        .branch_count(branch_count4), .miss_count(miss_count4)
    );

    int nvec = 0;
    int nerr = 0;

    // Reference model: counters as plain integers 0..3, statistics as integers.
    int          m_pht [16];
    int          m_bc, m_mc, m_bc4, m_mc4;
    bit          m_fail, m_res;
    logic [10:0] m_fb;

    function automatic int min_i(int a, int b); return (a < b) ? a : b; endfunction
    function automatic int max_i(int a, int b); return (a > b) ? a : b; endfunction

    // Clock edge, then update model from the inputs that were present at the edge.
    task automatic tick();
        bit actual, miss;
        int idx;
        @(posedge clk);
        #1;
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) m_pht[i] = 1;
            m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
            m_fail = 0; m_res = 0; m_fb = '0;
        end else if (res_valid && res_branch_type != 2'd0) begin
            actual = (res_branch_type == 2'd1) ? W_zero :
                     (res_branch_type == 2'd2) ? W_negative : carry;
            miss   = (actual != res_pred_taken);
            m_res  = actual;
            m_fail = miss;
            m_fb   = res_pred_taken ? res_fallthrough : res_target;
            idx    = int'(res_pc) % 16;
            m_pht[idx] = actual ? min_i(m_pht[idx] + 1, 3) : max_i(m_pht[idx] - 1, 0);
            m_bc  = min_i(m_bc + 1, 65535);
            m_bc4 = min_i(m_bc4 + 1, 15);
            if (miss) begin
                m_mc  = min_i(m_mc + 1, 65535);
                m_mc4 = min_i(m_mc4 + 1, 15);
            end
        end else begin
            m_fail = 0;
        end
    endtask

    task automatic idle_inputs();
        res_valid = 0; res_pc = '0; res_branch_type = 2'd0; res_pred_taken = 0;
        res_target = '0; res_fallthrough = '0; W_zero = 0; W_negative = 0; carry = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 0;
        tick();
        reset_n = 1;
    endtask

    task automatic resolve(input logic [10:0] pc, input logic [1:0] bt, input bit pred,
                           input bit z, input bit n, input bit c,
                           input logic [10:0] tgt, input logic [10:0] ft);
        res_valid = 1; res_pc = pc; res_branch_type = bt; res_pred_taken = pred;
        W_zero = z; W_negative = n; carry = c; res_target = tgt; res_fallthrough = ft;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            fetch_pc = 11'(i);
            #1;
            nvec++;
            if (fetch_predict !== 1'b0) begin
                nerr++; $display("FAIL reset_predict idx=%0d got %b want 0", i, fetch_predict);
            end
        end
        nvec++;
        if (branch_count !== 16'd0 || miss_count !== 16'd0 || flush !== 1'b0 ||
            prediction_failed !== 1'b0 || failback_addr !== 11'd0 || branch_result !== 1'b0) begin
            nerr++;
            $display("FAIL reset_state bc=%0d mc=%0d fl=%b pf=%b fb=%h br=%b want all 0",
                     branch_count, miss_count, flush, prediction_failed, failback_addr, branch_result);
        end
    endtask

    task automatic test_training();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            resolve(11'h005, 2'b01, 0, 1, 0, 0, 11'h010, 11'h006);
            tick();
            nvec++;
            if (prediction_failed !== 1'b1 || flush !== 1'b1) begin
                nerr++; $display("FAIL train_pulse k=%0d got pf=%b fl=%b want 1", k, prediction_failed, flush);
            end
        end
        idle_inputs();
        fetch_pc = 11'h005;
        #1;
        nvec++;
        if (fetch_predict !== 1'b1 || m_pht[5] != 3) begin
            nerr++; $display("FAIL train_predict got %b want 1 (model cnt %0d)", fetch_predict, m_pht[5]);
        end
        nvec++;
        if (miss_count !== 16'd3 || branch_count !== 16'd3) begin
            nerr++; $display("FAIL train_counts got mc=%0d bc=%0d want 3/3", miss_count, branch_count);
        end
        tick();
        nvec++;
        if (flush !== 1'b0) begin
            nerr++; $display("FAIL train_pulse_end got %b want 0", flush);
        end
    endtask

    task automatic test_recovery();
        do_reset();
        resolve(11'h040, 2'b11, 1, 0, 0, 0, 11'h456, 11'h123);
        tick();
        idle_inputs();
        nvec++;
        if (flush !== 1'b1 || failback_addr !== 11'h123 || branch_result !== 1'b0) begin
            nerr++;
            $display("FAIL recovery got fl=%b fb=%h br=%b want 1/123/0", flush, failback_addr, branch_result);
        end
        // Hit: failback still updates, no pulse.
        resolve(11'h041, 2'b10, 1, 0, 1, 0, 11'h2AA, 11'h042);
        tick();
        idle_inputs();
        nvec++;
        if (flush !== 1'b0 || failback_addr !== 11'h042 || branch_result !== 1'b1) begin
            nerr++;
            $display("FAIL recovery_hit got fl=%b fb=%h br=%b want 0/042/1", flush, failback_addr, branch_result);
        end
        tick();
        nvec++;
        if (failback_addr !== 11'h042 || branch_result !== 1'b1 || branch_count !== 16'd2) begin
            nerr++;
            $display("FAIL recovery_hold got fb=%h br=%b bc=%0d want 042/1/2", failback_addr, branch_result, branch_count);
        end
    endtask

    task automatic test_same_index();
        do_reset();
        fetch_pc = 11'h00A;
        resolve(11'h00A, 2'b01, 0, 1, 0, 0, 11'h0, 11'h0);
        #1;
        nvec++;
        if (fetch_predict !== 1'b0) begin
            nerr++; $display("FAIL race_pre got %b want 0", fetch_predict);
        end
        tick();
        idle_inputs();
        #1;
        nvec++;
        if (fetch_predict !== 1'b1) begin
            nerr++; $display("FAIL race_post got %b want 1", fetch_predict);
        end
        // Alias: 0x01A shares counter 0xA.
        fetch_pc = 11'h01A;
        #1;
        nvec++;
        if (fetch_predict !== 1'b1) begin
            nerr++; $display("FAIL alias got %b want 1", fetch_predict);
        end
    endtask

    task automatic test_ignored_saturation();
        do_reset();
        resolve(11'h003, 2'b00, 1, 0, 0, 0, 11'h111, 11'h222);
        tick();
        idle_inputs();
        nvec++;
        if (branch_count !== 16'd0 || flush !== 1'b0 || failback_addr !== 11'h000) begin
            nerr++; $display("FAIL ignored got bc=%0d fl=%b fb=%h want 0/0/000", branch_count, flush, failback_addr);
        end
        for (int k = 0; k < 20; k++) begin
            resolve(11'(k), 2'b11, 1, 0, 0, 0, 11'h0, 11'(k + 1));
            tick();
        end
        idle_inputs();
        nvec++;
        if (miss_count4 !== 4'd15 || branch_count4 !== 4'd15) begin
            nerr++; $display("FAIL sat4 got mc=%0d bc=%0d want 15/15", miss_count4, branch_count4);
        end
        nvec++;
        if (miss_count !== 16'd20 || branch_count !== 16'd20) begin
            nerr++; $display("FAIL sat16 got mc=%0d bc=%0d want 20/20", miss_count, branch_count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        resolve(11'h007, 2'b01, 1, 0, 0, 0, 11'h100, 11'h008);
        tick();
        nvec++;
        if (flush !== 1'b1 || failback_addr !== 11'h008) begin
            nerr++; $display("FAIL b2b_first got fl=%b fb=%h want 1/008", flush, failback_addr);
        end
        resolve(11'h009, 2'b10, 0, 0, 1, 0, 11'h300, 11'h00A);
        tick();
        nvec++;
        if (flush !== 1'b1 || failback_addr !== 11'h300 || miss_count !== 16'd2) begin
            nerr++; $display("FAIL b2b_second got fl=%b fb=%h mc=%0d want 1/300/2", flush, failback_addr, miss_count);
        end
        idle_inputs();
        tick();
        nvec++;
        if (flush !== 1'b0) begin
            nerr++; $display("FAIL b2b_end got %b want 0", flush);
        end
    endtask

    task automatic test_midrun_reset();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            resolve(11'h003, 2'b01, 0, 1, 0, 0, 11'h0, 11'h0);
            tick();
        end
        resolve(11'h004, 2'b01, 0, 1, 0, 0, 11'h055, 11'h005);
        reset_n = 0;
        tick();
        reset_n = 1;
        idle_inputs();
        nvec++;
        if (flush !== 1'b0 || branch_count !== 16'd0 || miss_count !== 16'd0 || failback_addr !== 11'd0) begin
            nerr++;
            $display("FAIL midreset got fl=%b bc=%0d mc=%0d fb=%h want 0", flush, branch_count, miss_count, failback_addr);
        end
        // One taken step from 01 must predict taken; proves every entry is back to 01.
        for (int i = 0; i < 16; i++) begin
            resolve(11'(i), 2'b11, 1, 0, 0, 1, 11'h0, 11'h0);
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 16; i++) begin
            fetch_pc = 11'(i);
            #1;
            nvec++;
            if (fetch_predict !== 1'b1) begin
                nerr++; $display("FAIL midreset_pht idx=%0d got %b want 1", i, fetch_predict);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            fetch_pc = 11'($urandom_range(0, 2047));
            resolve(11'($urandom_range(0, 2047)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)));
            res_valid = ($urandom_range(0, 3) != 0);
            #1;
            nvec++;
            if (fetch_predict !== (m_pht[int'(fetch_pc) % 16] >= 2)) begin
                nerr++; $display("FAIL rand_predict k=%0d pc=%h got %b want %b", k, fetch_pc,
                                 fetch_predict, (m_pht[int'(fetch_pc) % 16] >= 2));
            end
            tick();
            nvec++;
            if (prediction_failed !== m_fail || flush !== m_fail || branch_result !== m_res ||
                failback_addr !== m_fb || branch_count !== 16'(m_bc) || miss_count !== 16'(m_mc) ||
                branch_count4 !== 4'(m_bc4) || miss_count4 !== 4'(m_mc4)) begin
                nerr++;
                $display("FAIL rand_state k=%0d got pf=%b fl=%b br=%b fb=%h bc=%0d mc=%0d bc4=%0d mc4=%0d want pf=%b br=%b fb=%h bc=%0d mc=%0d bc4=%0d mc4=%0d",
                         k, prediction_failed, flush, branch_result, failback_addr, branch_count, miss_count,
                         branch_count4, miss_count4, m_fail, m_res, m_fb, m_bc, m_mc, m_bc4, m_mc4);
            end
        end
        idle_inputs();
    endtask

    initial begin
        reset_n  = 1;
        fetch_pc = '0;
        idle_inputs();
        #2;
        test_reset();
        test_training();
        test_recovery();
        test_same_index();
        test_ignored_saturation();
        test_back_to_back();
        test_midrun_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
